// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM encoding and event indices.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int unsigned EVT_STALL  = 0;
    localparam int unsigned EVT_FLUSH  = 1;
    localparam int unsigned EVT_RETIRE = 2;
    localparam int unsigned EVT_BRANCH = 3;

    localparam int unsigned NUM_EVT_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 32;
    localparam int unsigned SEL_W_DEF   = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag for a blocked increment.
module sat_counter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            // A full counter holds its value; the blocked increment is what sets the flag.
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_monitor.sv
// Pipeline performance monitor: cycle + event saturating counters, run-limit halt,
// atomic shadow snapshot and a registered indexed readout.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int unsigned NUM_EVT = NUM_EVT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [CNT_W-1:0]   limit_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]   cycle_o,
    output logic               run_o,
    output logic               halt_o,
    output logic [NUM_EVT:0]   ovf_o
);

    localparam int unsigned NCNT = NUM_EVT + 1;

    state_e           state_q;
    logic             run_q, halt_q;
    logic             count_en_c;
    logic             hit_c;
    logic [NCNT-1:0]  inc_c;
    logic [NCNT-1:0]  ovf_c;
    logic [CNT_W-1:0] cyc_post_c;
    logic [CNT_W-1:0] rd_mux_c;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] live_c   [NCNT];
    logic [CNT_W-1:0] shadow_q [NCNT];

    assign count_en_c = (state_q == ST_RUN) && !clear_i;
    assign inc_c      = {evt_i & {NUM_EVT{count_en_c}}, count_en_c};

    // Index 0 is the cycle counter, index k is event k-1.
    for (genvar g = 0; g < NCNT; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (inc_c[g]),
            .cnt_o (live_c[g]),
            .ovf_o (ovf_c[g])
        );
    end

    // Post-increment cycle value; a saturated counter stays put, so it only matches an all-ones limit.
    assign cyc_post_c = (&live_c[0]) ? live_c[0] : live_c[0] + CNT_W'(1);
    assign hit_c      = count_en_c && (limit_i != '0) && (cyc_post_c == limit_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (hit_c) begin
                        state_q <= ST_HALTED;
                        run_q   <= 1'b0;
                        halt_q  <= 1'b1;
                    end else if (!start_i) begin
                        state_q <= ST_IDLE;
                        run_q   <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_IDLE;
                    run_q   <= 1'b0;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    // Shadows take the pre-increment, pre-clear live values; clear alone leaves them intact.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NCNT; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap_i) begin
            for (int unsigned i = 0; i < NCNT; i++) begin
                shadow_q[i] <= live_c[i];
            end
        end
    end

    always_comb begin
        rd_mux_c = '0;
        for (int unsigned i = 0; i < NCNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_mux_c = shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_mux_c;
        end
    end

    assign rd_data_o = rd_data_q;
    assign cycle_o   = live_c[0];
    assign run_o     = run_q;
    assign halt_o    = halt_q;
    assign ovf_o     = ovf_c;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit instance for the main flows and a 4-bit one for saturation.
module tb_perf_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_start, a_clear, a_snap;
    logic [31:0] a_limit;
    logic [3:0]  a_evt, a_sel;
    logic [31:0] a_rd, a_cycle;
    logic        a_run, a_halt;
    logic [4:0]  a_ovf;

    logic        b_start, b_clear, b_snap;
    logic [3:0]  b_limit;
    logic [3:0]  b_evt, b_sel;
    logic [3:0]  b_rd, b_cycle;
    logic        b_run, b_halt;
    logic [4:0]  b_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    perf_monitor #(.NUM_EVT(4), .CNT_W(32), .SEL_W(4)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .clear_i(a_clear),
        .limit_i(a_limit), .evt_i(a_evt), .snap_i(a_snap), .rd_sel_i(a_sel),
        .rd_data_o(a_rd), .cycle_o(a_cycle), .run_o(a_run), .halt_o(a_halt), .ovf_o(a_ovf)
    );

    perf_monitor #(.NUM_EVT(4), .CNT_W(4), .SEL_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .clear_i(b_clear),
        .limit_i(b_limit), .evt_i(b_evt), .snap_i(b_snap), .rd_sel_i(b_sel),
        .rd_data_o(b_rd), .cycle_o(b_cycle), .run_o(b_run), .halt_o(b_halt), .ovf_o(b_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic a_read(input logic [3:0] sel, input logic [31:0] exp, input string tag);
        a_sel = sel;
        step(1);
        chk(tag, a_rd, exp);
    endtask

    task automatic a_snapshot();
        a_snap = 1'b1;
        step(1);
        a_snap = 1'b0;
    endtask

    initial begin
        a_start = 0; a_clear = 0; a_snap = 0; a_limit = 0; a_evt = 0; a_sel = 0;
        b_start = 0; b_clear = 0; b_snap = 0; b_limit = 0; b_evt = 0; b_sel = 0;

        // Reset and idle
        #23;
        chk("rst_cycle", a_cycle, 0);
        chk("rst_run",   32'(a_run), 0);
        chk("rst_halt",  32'(a_halt), 0);
        chk("rst_ovf",   32'(a_ovf), 0);
        chk("rst_rd",    a_rd, 0);
        rst = 1'b1;
        step(1);
        for (int i = 0; i < 10; i++) begin
            a_evt = 4'(i);
            step(1);
        end
        a_evt = 0;
        chk("idle_cycle", a_cycle, 0);
        chk("idle_run",   32'(a_run), 0);
        a_snapshot();
        for (int s = 0; s < 5; s++) a_read(4'(s), 0, "idle_read");

        // Limit halt at 30 with stall every third counted cycle
        a_limit = 30;
        a_start = 1;
        step(1);
        chk("lim_run_entry", 32'(a_run), 1);
        chk("lim_cycle_entry", a_cycle, 0);
        for (int c = 1; c <= 30; c++) begin
            a_evt = (c % 3 == 0) ? 4'b0001 : 4'b0000;
            step(1);
            if (c == 29) chk("lim_no_early_halt", 32'(a_halt), 0);
        end
        chk("lim_cycle", a_cycle, 30);
        chk("lim_halt",  32'(a_halt), 1);
        chk("lim_run_off", 32'(a_run), 0);
        a_evt = 4'hF;
        step(10);
        a_evt = 0;
        chk("lim_hold_cycle", a_cycle, 30);
        chk("lim_hold_halt",  32'(a_halt), 1);

        // Clear with snap while halted; start held so RUN follows next edge
        a_clear = 1; a_snap = 1;
        step(1);
        a_clear = 0; a_snap = 0;
        chk("clr_cycle", a_cycle, 0);
        chk("clr_halt",  32'(a_halt), 0);
        chk("clr_run",   32'(a_run), 0);
        chk("clr_ovf",   32'(a_ovf), 0);
        step(1);
        chk("clr_then_run", 32'(a_run), 1);
        chk("clr_then_cycle", a_cycle, 0);
        a_clear = 1; a_start = 0;
        step(1);
        a_clear = 0;
        chk("clr2_run", 32'(a_run), 0);
        a_limit = 30;
        a_read(0, 30, "clr_shadow_cyc");
        a_read(1, 10, "clr_shadow_stall");
        a_read(2, 0, "clr_shadow_flush");
        a_read(7, 0, "rd_out_of_range");

        // Pause / resume with flush held high
        a_limit = 0;
        a_evt = 4'b0010;
        a_start = 1; step(5);
        a_start = 0; step(4);
        chk("pause_cycle", a_cycle, 5);
        chk("pause_run", 32'(a_run), 0);
        a_start = 1; step(7);
        a_start = 0; step(1);
        chk("resume_cycle", a_cycle, 12);
        a_evt = 0;
        a_snapshot();
        a_read(2, 12, "pause_flush");
        a_read(0, 12, "pause_shadow_cyc");
        a_read(1, 0, "pause_stall");

        // Snapshot atomicity while counting
        a_clear = 1; step(1); a_clear = 0;
        a_start = 1; step(1);
        step(7);
        chk("snap_pre_cycle", a_cycle, 7);
        a_sel = 0; a_snap = 1;
        step(1);
        a_snap = 0;
        chk("snap_same_cycle_old", a_rd, 12);
        chk("snap_live_moves", a_cycle, 8);
        step(1);
        chk("snap_new_visible", a_rd, 7);
        step(5);
        chk("snap_stable", a_rd, 7);
        chk("snap_cycle_later", a_cycle, 14);

        // Saturation on the 4-bit instance
        b_evt = 4'b0100;
        b_start = 1; step(1);
        step(15);
        chk("sat_cycle_15", 32'(b_cycle), 15);
        chk("sat_ovf_before", 32'(b_ovf), 0);
        step(1);
        chk("sat_ovf_set", 32'(b_ovf), 32'b01001);
        step(4);
        chk("sat_cycle_hold", 32'(b_cycle), 15);
        chk("sat_run", 32'(b_run), 1);
        b_snap = 1; step(1); b_snap = 0;
        b_sel = 3; step(1);
        chk("sat_retire", 32'(b_rd), 15);
        b_sel = 9; step(1);
        chk("sat_sel_oob", 32'(b_rd), 0);

        // Limit lowered below count: no halt until saturated and limit all-ones
        b_evt = 0; b_start = 0; b_clear = 1; step(1); b_clear = 0;
        chk("sat_clr_ovf", 32'(b_ovf), 0);
        b_start = 1; step(1);
        step(10);
        chk("low_cycle10", 32'(b_cycle), 10);
        b_limit = 5;
        step(10);
        chk("low_no_halt", 32'(b_halt), 0);
        chk("low_sat", 32'(b_cycle), 15);
        b_limit = 15;
        step(1);
        chk("allones_halt", 32'(b_halt), 1);
        chk("allones_run", 32'(b_run), 0);

        // Asynchronous reset mid-run
        #3;
        chk("mid_pre_running", 32'(a_run), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cycle", a_cycle, 0);
        chk("mid_rst_run",   32'(a_run), 0);
        chk("mid_rst_rd",    a_rd, 0);
        chk("mid_rst_b_halt", 32'(b_halt), 0);
        a_start = 0; b_start = 0;
        #7;
        rst = 1'b1;
        step(1);
        a_read(0, 0, "mid_rst_shadow");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
Name: perf_monitor

Overview:
- Synthesizable pipeline performance monitor that sits beside the pipelined CPU and observes per-cycle hazard, retire and other event strobes.
- Holds one cycle counter plus NUM_EVT event counters, all saturating.
- Asserts halt_o after a programmable number of run cycles.
- Supports atomic snapshot of all counters into shadow registers, with a registered indexed readout port for test and debug logic.

Parameters:
- NUM_EVT, 4, number of event inputs/counters (1..15); default order is stall, flush, retire, branch.
- CNT_W, 32, width of every counter, limit_i and rd_data_o.
- SEL_W, 4, width of rd_sel_i; must satisfy 2**SEL_W >= NUM_EVT+1.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  run enable; level-sensitive.
- clear_i  in  1  synchronous clear of counters, flags and state.
- limit_i  in  CNT_W  run-cycle limit; 0 = unlimited.
- evt_i  in  NUM_EVT  event strobes, one bit per counter, sampled each cycle.
- snap_i  in  1  copy all live counters into shadow registers.
- rd_sel_i  in  SEL_W  0 = cycle shadow; k = event k-1 shadow.
- rd_data_o  out  CNT_W  registered readout of selected shadow.
- cycle_o  out  CNT_W  live cycle counter.
- run_o  out  1  state == RUN.
- halt_o  out  1  state == HALTED.
- ovf_o  out  NUM_EVT+1  sticky saturation flags; bit 0 = cycle, bit k = event k-1.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; all live counters, shadows, ovf_o and rd_data_o are 0; run_o = 0; halt_o = 0.
- State machine:
  - IDLE -> RUN when start_i = 1.
  - RUN -> IDLE when start_i = 0 (pause: counters hold).
  - RUN -> HALTED when the post-increment cycle value equals limit_i and limit_i != 0.
  - HALTED is exited only by clear_i or reset.
- Counting happens only in RUN, and also in the cycle that causes RUN -> HALTED:
  - cycle counter +1 every cycle;
  - event counter k +1 when evt_i[k] = 1.
  - No counting in IDLE or HALTED; evt_i is ignored there.
- Cycle RUN is first entered: counting starts on the first clock edge at which state is already RUN, i.e. the edge after start_i is sampled high. With limit_i = L, exactly L cycles are counted, cycle_o = L, and halt_o rises on the same edge as the Lth count.
- Saturation:
  - A counter at all-ones stays at all-ones, and its ovf_o bit sets the same edge an increment is blocked.
  - ovf bits are sticky until clear_i or reset.
  - A saturated cycle counter never matches limit_i unless limit_i = all-ones.
- limit_i is sampled every cycle. If the limit is lowered below the current count, no halt occurs until the cycle counter saturates.
- snap_i: shadow[i] <= live[i] as held before this edge's increment, for all counters in the same edge (atomic).
- clear_i:
  - Highest priority: live counters, ovf_o and state all go to 0/IDLE.
  - Shadows are not cleared.
  - clear_i together with snap_i: shadows capture the pre-clear values.
  - clear_i together with start_i = 1: state IDLE this edge; RUN on the next edge if start_i is still 1.
- Readout:
  - rd_data_o <= shadow[rd_sel_i], with one-cycle latency.
  - rd_sel_i > NUM_EVT reads 0.
  - snap_i and a read in the same cycle return the old shadow; the new shadow is visible from the following read.
- Reset asserted mid-RUN: immediate return to the reset values; no partial state is retained.

Decomposition:
- Shared package perf_pkg:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2);
  - event index constants EVT_STALL = 0, EVT_FLUSH = 1, EVT_RETIRE = 2, EVT_BRANCH = 3.
- One sub-module, sat_counter: CNT_W-wide saturating counter with inc, clr and ovf outputs. It is instantiated NUM_EVT+1 times via generate.
- Shadow array, FSM and readout mux stay in perf_monitor.

Test Plan:
- Reset/idle: rst_i low then high, start_i = 0 for 10 cycles, toggling evt_i -> cycle_o = 0, all reads 0, run_o = 0, halt_o = 0.
- Limit halt: limit_i = 30, start_i = 1, evt_i[0] high every 3rd cycle -> halt_o rises on the edge where cycle_o = 30; snap, then read sel 0 = 30, sel 1 = 10; cycle_o still 30 ten cycles later.
- Pause/resume: limit_i = 0; run 5 cycles, start_i = 0 for 4, run 7 more -> cycle_o = 12; evt_i[1] held high throughout gives sel 2 = 12 after snap.
- Saturation: CNT_W = 4 instance, limit_i = 0, evt_i[2] = 1 for 20 run cycles -> sel 3 = 15, ovf_o[3] = 1, cycle_o = 15, ovf_o[0] = 1.
- Snapshot atomicity: snap_i at cycle_o = 7 while counting continues -> sel 0 reads 7 for all later reads until the next snap; a snap/read in the same cycle returns the previous shadow.
- Clear priority: clear_i with snap_i while halted at 30 -> shadow sel 0 = 30, cycle_o = 0, halt_o = 0, ovf_o = 0, state IDLE, then RUN the next edge with start_i = 1.
